// File: rtl/acc_drain_if.sv
// Bundle of the drain-side signals of acc_drain: PE accumulator capture inputs,
// the downstream valid/ready output word, and the status outputs.
interface acc_drain_if #(
    parameter int N_PE  = 4,
    parameter int ACC_W = 20
);
    localparam int LANE_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic [N_PE*ACC_W-1:0] iAcc;
    logic [N_PE-1:0]       iClearAcc;
    logic                  iReady;
    logic                  iClrErr;
    logic                  oValid;
    logic [ACC_W-1:0]      oData;
    logic [LANE_W-1:0]     oLane;
    logic                  oLast;
    logic                  oOverflow;
    logic [15:0]           oFrameCnt;

    modport slave (
        input  iAcc, iClearAcc, iReady, iClrErr,
        output oValid, oData, oLane, oLast, oOverflow, oFrameCnt
    );

    modport master (
        output iAcc, iClearAcc, iReady, iClrErr,
        input  oValid, oData, oLane, oLast, oOverflow, oFrameCnt
    );
endinterface

// File: rtl/acc_drain.sv
// Drains one row of PE accumulators lane by lane into a valid/ready stream.
// Define ACC_DRAIN_OVERWRITE_EN to let an overflowing capture replace the held value.
module acc_drain #(
    parameter int N_PE  = 4,
    parameter int ACC_W = 20
) (
    input  logic        iClk,
    input  logic        iRst,
    acc_drain_if.slave  bus
);
    localparam int LANE_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_PE - 1);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [LANE_W-1:0] ptr_r, ptr_s, nptr_s;
    logic [N_PE-1:0]   full_r, full_s;
    logic [ACC_W-1:0]  hold_r [N_PE];
    logic [ACC_W-1:0]  hold_s [N_PE];
    logic              valid_r;
    logic [ACC_W-1:0]  data_r, data_s;
    logic [LANE_W-1:0] lane_r, lane_s;
    logic              last_r, last_s;
    logic              ovf_r, ovf_s, ovf_event_s;
    logic [15:0]       frame_r, frame_s;
    logic              hs_s;

    assign bus.oValid    = valid_r;
    assign bus.oData     = data_r;
    assign bus.oLane     = lane_r;
    assign bus.oLast     = last_r;
    assign bus.oOverflow = ovf_r;
    assign bus.oFrameCnt = frame_r;

    // Next-state, presentation, capture and status logic
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        full_s      = full_r;
        hold_s      = hold_r;
        data_s      = data_r;
        lane_s      = lane_r;
        last_s      = last_r;
        ovf_event_s = 1'b0;
        hs_s        = (state_r == PRESENT) && bus.iReady;
        nptr_s      = (ptr_r == LAST_LANE) ? '0 : ptr_r + LANE_W'(1);

        case (state_r)
            IDLE: begin
                if (full_r[ptr_r]) begin
                    state_s = PRESENT;
                    data_s  = hold_r[ptr_r];
                    lane_s  = ptr_r;
                    last_s  = (ptr_r == LAST_LANE);
                end else begin
                    state_s = IDLE;
                end
            end
            PRESENT: begin
                if (bus.iReady) begin
                    full_s[ptr_r] = 1'b0;
                    ptr_s         = nptr_s;
                    // Chain straight into the next lane to keep one word per cycle
                    if (full_r[nptr_s] && (nptr_s != ptr_r)) begin
                        state_s = PRESENT;
                        data_s  = hold_r[nptr_s];
                        lane_s  = nptr_s;
                        last_s  = (nptr_s == LAST_LANE);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = PRESENT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        for (int k = 0; k < N_PE; k++) begin
            if (bus.iClearAcc[k]) begin
                // A lane leaving this cycle frees its slot for the new value
                if (!full_r[k] || (hs_s && (ptr_r == LANE_W'(k)))) begin
                    hold_s[k] = bus.iAcc[k*ACC_W +: ACC_W];
                    full_s[k] = 1'b1;
                end else begin
                    ovf_event_s = 1'b1;
`ifdef ACC_DRAIN_OVERWRITE_EN
                    if ((state_r == PRESENT) && (ptr_r == LANE_W'(k))) begin
                        hold_s[k] = hold_r[k];
                    end else begin
                        hold_s[k] = bus.iAcc[k*ACC_W +: ACC_W];
                    end
`else
                    hold_s[k] = hold_r[k];
`endif
                end
            end else begin
                hold_s[k] = hold_r[k];
            end
        end

        if (ovf_event_s) begin
            ovf_s = 1'b1;
        end else if (bus.iClrErr) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end

        if (hs_s && last_r) begin
            frame_s = frame_r + 16'd1;
        end else begin
            frame_s = frame_r;
        end
    end

    // State, lane storage and output registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            full_r  <= '0;
            for (int k = 0; k < N_PE; k++) begin
                hold_r[k] <= '0;
            end
            valid_r <= 1'b0;
            data_r  <= '0;
            lane_r  <= '0;
            last_r  <= 1'b0;
            ovf_r   <= 1'b0;
            frame_r <= 16'd0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            full_r  <= full_s;
            hold_r  <= hold_s;
            valid_r <= (state_s == PRESENT);
            data_r  <= data_s;
            lane_r  <= lane_s;
            last_r  <= last_s;
            ovf_r   <= ovf_s;
            frame_r <= frame_s;
        end
    end
endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 The block SHALL have parameter N_PE, default 4, meaning the number of PEs (lanes) in one array row drained by this block.
REQ-002 The block SHALL have parameter ACC_W, default 20, meaning the accumulator width per lane.
REQ-003 The block SHALL have port iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port iAcc  input  N_PE*ACC_W  PE accumulator values; lane k occupies bits [k*ACC_W +: ACC_W].
REQ-006 The block SHALL have port iClearAcc  input  N_PE  per-lane skewed clear; bit k high marks iAcc lane k as the final sum.
REQ-007 The block SHALL have port iReady  input  1  downstream ready.
REQ-008 The block SHALL have port iClrErr  input  1  clears the sticky overflow flag.
REQ-009 The block SHALL have port oValid  output  1  oData/oLane/oLast valid.
REQ-010 The block SHALL have port oData  output  ACC_W  drained accumulator value.
REQ-011 The block SHALL have port oLane  output  clog2(N_PE)  lane index of oData.
REQ-012 The block SHALL have port oLast  output  1  high with lane N_PE-1 (end of frame).
REQ-013 The block SHALL have port oOverflow  output  1  sticky: capture attempted into a full lane.
REQ-014 The block SHALL have port oFrameCnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-015 Each lane k SHALL have a holding register hold[k] and a full flag full[k].
REQ-016 In a cycle with iClearAcc[k]=1 and full[k]=0, hold[k] SHALL load iAcc lane k and full[k] SHALL be set at the next edge.
REQ-017 A read pointer ptr SHALL start at 0 and visit lanes strictly in order 0..N_PE-1, then wrap to 0.
REQ-018 The FSM SHALL have two states: IDLE (oValid=0) and PRESENT (oValid=1).
REQ-019 IDLE SHALL move to PRESENT at the edge where full[ptr]=1, registering oData=hold[ptr], oLane=ptr and oLast=(ptr==N_PE-1); the latency from capture to oValid is therefore 2 cycles.
REQ-020 In PRESENT, oData, oLane and oLast SHALL stay stable until oValid&iReady.
REQ-021 On handshake (oValid&iReady), the block SHALL clear full[ptr] and advance ptr with wrap; if the new ptr lane is full it SHALL stay in PRESENT with the next value, otherwise it SHALL go to IDLE.
REQ-022 Back-to-back handshakes SHALL sustain 1 word/cycle when lanes are full.
REQ-023 oFrameCnt SHALL increment on a handshake with oLast=1.
REQ-024 If iClearAcc[k]=1 in the same cycle that lane k is handshaken out, the new value SHALL be captured and full[k] SHALL remain 1 (no overflow).
REQ-025 If iClearAcc[k]=1 while full[k]=1 and the lane is not being handshaken in that cycle, oOverflow SHALL set; the capture SHALL follow REQ-038.
REQ-026 iClrErr SHALL clear oOverflow; a new overflow event in the same cycle SHALL take priority and keep the flag at 1.
REQ-027 Lanes other than ptr SHALL capture independently; there is no ordering dependency between captures.

Reset
REQ-028 iRst=1 SHALL immediately force oValid=0, oData=0, oLane=0, oLast=0, oOverflow=0, oFrameCnt=0, all full[]=0, all hold[]=0, ptr=0, and state IDLE.
REQ-029 Reset mid-frame SHALL discard all held values; after release, draining SHALL restart at lane 0.
REQ-030 Capture and handshake SHALL be ignored while iRst=1.

Configuration
REQ-031 The block SHALL have macro ACC_DRAIN_OVERWRITE_EN selecting the overflow capture policy.
REQ-032 With ACC_DRAIN_OVERWRITE_EN undefined, an overflowing capture SHALL be dropped and hold[k] SHALL keep its old value.
REQ-033 With ACC_DRAIN_OVERWRITE_EN defined, hold[k] SHALL take the new value, except when k==ptr in PRESENT, where the value is dropped so that oData stays stable.
REQ-034 oOverflow SHALL set under both policies.

Verification
REQ-035 N_PE=4, lane values 10,20,30,40 cleared in skewed cycles t..t+3, iReady=1 -> oData 10,20,30,40 on consecutive cycles, oLane 0..3, oLast only on 40, oFrameCnt=1.
REQ-036 Same stimulus with iReady=0 for 5 cycles -> oValid=1, oData=10 held stable, then the burst of 4 words once iReady=1.
REQ-037 Lane 2 captured before lane 0 -> no output until lane 0 is captured; then the order is 0,1,2.
REQ-038 Second clear on lane 1 (value 99) while full -> oOverflow=1; the value drained is the old one without the macro and 99 with the macro; iClrErr -> oOverflow=0.
REQ-039 Clear on lane 0 (value 77) in the same cycle that lane 0 is handshaken -> oOverflow stays 0 and the next frame's lane 0 reads 77.
REQ-040 iRst pulse after lanes 0,1 are captured -> all outputs 0; a new frame 5,6,7,8 drains starting at lane 0.
